stack_frame_ctrl: RTL and testbench
===================================

# stack_frame_ctrl

Call-frame controller sitting in front of `SuperStack` in the WebAssembly execution core. It accepts `CALL`/`RETURN` commands from the instruction decoder and sequences the stack's `op`, `offset`, `data` and `underflow_limit` inputs so each function sees a protected frame. On call, the frame base moves down over the arguments. On return, at most one result is moved to the caller's frame base and the previous limit is restored. Saved limits live in an internal frame table.

## Interface
- `WIDTH`, 8: stack data width; matches `SuperStack`.
- `DEPTH`, 1: `SuperStack` depth exponent; index/limit width is `DEPTH+1`.
- `FRAMES`, 4: maximum nested call frames, power of two.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: controller idle; a command is accepted when `cmd_valid & cmd_ready`.
- `cmd_ret` in 1: 0 = CALL, 1 = RETURN.
- `cmd_count` in `DEPTH+1`: argument count for CALL; result count for RETURN, which must be 0 or 1.
- `stk_index` in `DEPTH+1`: `SuperStack.index`.
- `stk_out` in `WIDTH`: `SuperStack.out`.
- `stk_error` in 2: `SuperStack.error`.
- `stk_op` out 3: `SuperStack.op`.
- `stk_offset` out `DEPTH+1`: `SuperStack.offset`.
- `stk_data` out `WIDTH`: `SuperStack.data`.
- `stk_underflow_limit` out `DEPTH+1`: `SuperStack.underflow_limit`, registered.
- `done` out 1: one-cycle pulse when a command completes successfully or with an error.
- `err` out 2: valid with `done`.
  - 0: OK.
  - 1: FRAME_OVERFLOW.
  - 2: FRAME_UNDERFLOW.
  - 3: BAD_ARITY.
- `depth` out `$clog2(FRAMES)+1`: current nesting level.

## Operation
- **States:** `IDLE`, `CALL_COMMIT`, `RET_ISSUE`, `RET_CHECK`, `DONE`.
- **IDLE:**
  - `cmd_ready=1`, `stk_op=NONE`.
  - On accept, latch `cmd_ret`, `cmd_count` and `stk_index`, then go to `CALL_COMMIT` or `RET_ISSUE`.
- **CALL_COMMIT:**
  - Let `avail = stk_index − stk_underflow_limit`.
  - If `cmd_count > avail`: `err=3`.
  - Else if `depth == FRAMES`: `err=1`.
  - Otherwise: push the current limit into the frame table, `depth++`, and set `stk_underflow_limit = stk_index − cmd_count`.
  - Go to `DONE`.
- **RET_ISSUE:**
  - If `depth == 0`: `err=2`, go to `DONE`.
  - If `cmd_count > 1`, or `cmd_count == 1` with `avail == 0`: `err=3`, go to `DONE`; the stack is not touched.
  - `cmd_count == 1`: drive `stk_op=INDEX_RESET_AND_PUSH`, `stk_offset=stk_underflow_limit`, `stk_data=stk_out`. `stk_out` is the registered TOS and is stable in this cycle.
  - `cmd_count == 0`: drive `stk_op=INDEX_RESET`, `stk_offset=stk_underflow_limit`.
  - Go to `RET_CHECK`.
- **RET_CHECK:**
  - `stk_op=NONE`.
  - If `stk_error != NONE`: `err=3`; the frame table is unchanged.
  - Otherwise: pop the frame table into `stk_underflow_limit`, `depth--`.
  - Go to `DONE`.
- **DONE:** `done=1` for one cycle, then `IDLE`.
- **Boundary behaviour:**
  - All `stk_op` values other than those listed are never issued.
  - Commands offered while busy are not accepted; `cmd_valid` must be held.
  - Subtractions are unsigned at `DEPTH+1` bits. The arity checks above guarantee no wrap.
- **Reset (any time, including mid-command):**
  - State `IDLE`, `depth=0`, `stk_underflow_limit=0`.
  - `stk_op=NONE`, `stk_offset=0`, `stk_data=0`.
  - `done=0`, `err=0`, `cmd_ready=1`.
  - Frame table contents need not be cleared.

## Timing
- **CALL latency:** accept at edge 0, limit updated at edge 1, `done` high in cycle 2.
- **RETURN latency:** accept at edge 0, stack op driven in cycle 1, stack updates at edge 2, error sampled and limit restored at edge 3, `done` high in cycle 3→4.
- **Throughput:** `cmd_ready` is low from accept until the cycle after `done`. This gives one command per 3 cycles (CALL) or per 5 cycles (RETURN).
- **Registered outputs:** `stk_op`, `stk_offset`, `stk_data` and `stk_underflow_limit` are registered, so there is no combinational path from `cmd_*` to `stk_*`.

## Structure
- **Op codes and status codes:** taken from the existing `SuperStack.vh` (`NONE`, `INDEX_RESET`, `INDEX_RESET_AND_PUSH`, `UNDERFLOW`, …).
- **Error codes:** a new `stack_frame_ctrl.vh` holds `FRAME_OK`, `FRAME_OVERFLOW`, `FRAME_UNDERFLOW`, `FRAME_BAD_ARITY` and the state encodings.
- **Frame table:** one sub-module, `frame_table`, a FRAMES×(`DEPTH+1`) register LIFO with push/pop/top/count ports.

## Test plan
All scenarios use `DEPTH=2`, `FRAMES=2`, and a real `SuperStack` instance.

1. **CALL:** push 3,4,5, then CALL `count=2` → `done`, `err=0`, `stk_underflow_limit=1`, `depth=1`.
2. **RETURN with result:** after (1), push 7, then RETURN `count=1` → `index=2`, `out=7`, `out1=3`, limit 0, `depth=0`, `err=0`.
3. **Frame overflow:** CALL `count=0` three times → third returns `err=1`; `depth` stays 2 and the limit is unchanged.
4. **RETURN at depth 0:** → `err=2`, no stack op issued (`stk_op` stays `NONE` throughout).
5. **Bad arity:**
   - CALL `count=3` with only 1 item above the limit → `err=3`.
   - RETURN `count=1` on an empty frame → `err=3`; the limit is unchanged.
6. **Reset mid-command:** assert `reset` in `RET_ISSUE` → next cycle `stk_op=NONE`, limit 0, `depth=0`, `cmd_ready=1`, no `done` pulse.

Source files
------------

// File: rtl/stack_frame_ctrl_pkg.sv
// Shared encodings for the call-frame controller: stack op/status codes,
// frame completion codes and controller states.
package stack_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    STK_NONE                 = 3'd0,
    STK_PUSH                 = 3'd1,
    STK_POP                  = 3'd2,
    STK_REPLACE              = 3'd3,
    STK_INDEX_RESET          = 3'd4,
    STK_INDEX_RESET_AND_PUSH = 3'd5
  } stk_op_e;

  typedef enum logic [1:0] {
    STK_ERR_NONE      = 2'd0,
    STK_ERR_UNDERFLOW = 2'd1,
    STK_ERR_OVERFLOW  = 2'd2
  } stk_err_e;

  typedef enum logic [1:0] {
    FRAME_OK        = 2'd0,
    FRAME_OVERFLOW  = 2'd1,
    FRAME_UNDERFLOW = 2'd2,
    FRAME_BAD_ARITY = 2'd3
  } frame_err_e;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_CALL_COMMIT = 3'd1,
    ST_RET_ISSUE   = 3'd2,
    ST_RET_CHECK   = 3'd3,
    ST_DONE        = 3'd4
  } state_e;

endpackage

// File: rtl/stack_frame_ctrl_frame_table.sv
// LIFO of saved underflow limits, one entry per nested call frame.
// The caller never pushes when full or pops when empty.
module frame_table #(
  parameter int W      = 2,
  parameter int FRAMES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [W-1:0]              i_din,
  output logic [W-1:0]              o_top,
  output logic [$clog2(FRAMES):0]   o_count
);
  localparam int PW = $clog2(FRAMES);

  logic [W-1:0]  r_mem [FRAMES];
  logic [PW:0]   r_count;
  logic [PW-1:0] w_wr_idx;
  logic [PW-1:0] w_top_idx;

  assign w_wr_idx  = r_count[PW-1:0];
  assign w_top_idx = w_wr_idx - PW'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_count   = r_count;

  // occupancy counter; only this is cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_count <= '0;
    else if (i_push) r_count <= r_count + (PW+1)'(1);
    else if (i_pop)  r_count <= r_count - (PW+1)'(1);
  end

  // entry storage, written at the current fill level
  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_wr_idx] <= i_din;
  end

endmodule

// File: rtl/stack_frame_ctrl.sv
// Call-frame controller in front of SuperStack: sequences index-reset ops
// and the underflow limit so each callee sees a protected frame.
//   state          | meaning
//   ST_IDLE        | ready for a CALL/RETURN command
//   ST_CALL_COMMIT | arity/overflow check, save limit, lower limit over args
//   ST_RET_ISSUE   | depth/arity check, register the index-reset stack op
//   ST_RET_CHECK   | op cycle, then sample stack error and restore limit
//   ST_DONE        | one-cycle completion pulse with status
module stack_frame_ctrl
  import stack_frame_ctrl_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 1,
  parameter int FRAMES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_ret,
  input  logic [DEPTH:0]          cmd_count,
  input  logic [DEPTH:0]          stk_index,
  input  logic [WIDTH-1:0]        stk_out,
  input  logic [1:0]              stk_error,
  output logic [2:0]              stk_op,
  output logic [DEPTH:0]          stk_offset,
  output logic [WIDTH-1:0]        stk_data,
  output logic [DEPTH:0]          stk_underflow_limit,
  output logic                    done,
  output logic [1:0]              err,
  output logic [$clog2(FRAMES):0] depth
);
  localparam int IW = DEPTH + 1;
  localparam int DW = $clog2(FRAMES) + 1;

  state_e           r_state, w_state_nxt;
  logic [IW-1:0]    r_count, r_index;
  stk_op_e          r_op, w_op_nxt;
  logic [IW-1:0]    r_offset, w_offset_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic [IW-1:0]    r_limit, w_limit_nxt;
  frame_err_e       r_err, w_err_nxt;
  logic             r_settle, w_settle_nxt;
  logic             w_accept, w_push, w_pop, w_full;
  logic [IW-1:0]    w_avail, w_top;
  logic [DW-1:0]    w_depth;

  assign w_accept = cmd_valid && (r_state == ST_IDLE);
  assign w_avail  = r_index - r_limit;
  assign w_full   = (w_depth == DW'(FRAMES));

  frame_table #(.W(IW), .FRAMES(FRAMES)) u_frame_table (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (r_limit),
    .o_top   (w_top),
    .o_count (w_depth)
  );

  // state and registered stack-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op     <= STK_NONE;
      r_offset <= '0;
      r_data   <= '0;
      r_limit  <= '0;
      r_err    <= FRAME_OK;
      r_settle <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_offset <= w_offset_nxt;
      r_data   <= w_data_nxt;
      r_limit  <= w_limit_nxt;
      r_err    <= w_err_nxt;
      r_settle <= w_settle_nxt;
    end
  end

  // command operands captured at accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_index <= '0;
    end else if (w_accept) begin
      r_count <= cmd_count;
      r_index <= stk_index;
    end
  end

  // next-state and next registered outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = STK_NONE;
    w_offset_nxt = '0;
    w_data_nxt   = '0;
    w_limit_nxt  = r_limit;
    w_err_nxt    = r_err;
    w_settle_nxt = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_err_nxt   = FRAME_OK;
          w_state_nxt = cmd_ret ? ST_RET_ISSUE : ST_CALL_COMMIT;
        end
      end
      ST_CALL_COMMIT: begin
        if (r_count > w_avail) begin
          w_err_nxt = FRAME_BAD_ARITY;
        end else if (w_full) begin
          w_err_nxt = FRAME_OVERFLOW;
        end else begin
          w_push      = 1'b1;
          w_limit_nxt = r_index - r_count;
        end
        w_state_nxt = ST_DONE;
      end
      ST_RET_ISSUE: begin
        if (w_depth == '0) begin
          w_err_nxt   = FRAME_UNDERFLOW;
          w_state_nxt = ST_DONE;
        end else if ((r_count > IW'(1)) || ((r_count == IW'(1)) && (w_avail == '0))) begin
          w_err_nxt   = FRAME_BAD_ARITY;
          w_state_nxt = ST_DONE;
        end else begin
          w_op_nxt     = (r_count == IW'(1)) ? STK_INDEX_RESET_AND_PUSH : STK_INDEX_RESET;
          w_offset_nxt = r_limit;
          w_data_nxt   = (r_count == IW'(1)) ? stk_out : '0;
          w_settle_nxt = 1'b1;
          w_state_nxt  = ST_RET_CHECK;
        end
      end
      ST_RET_CHECK: begin
        // first cycle carries the op; the stack's status is valid one cycle later
        if (!r_settle) begin
          if (stk_error != STK_ERR_NONE) begin
            w_err_nxt = FRAME_BAD_ARITY;
          end else begin
            w_pop       = 1'b1;
            w_limit_nxt = w_top;
          end
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready           = (r_state == ST_IDLE);
  assign done                = (r_state == ST_DONE);
  assign err                 = done ? r_err : FRAME_OK;
  assign stk_op              = r_op;
  assign stk_offset          = r_offset;
  assign stk_data            = r_data;
  assign stk_underflow_limit = r_limit;
  assign depth               = w_depth;

endmodule

// File: tb/tb_stack_frame_ctrl.sv
// Randomized bench for stack_frame_ctrl with a behavioural stack stand-in
// and a queue-based frame/stack reference model.
module tb_stack_frame_ctrl;
  import stack_frame_ctrl_pkg::*;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 2;
  localparam int FRAMES = 2;
  localparam int IW     = DEPTH + 1;
  localparam int CAP    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_ret;
  logic [IW-1:0]    cmd_count;
  logic [IW-1:0]    stk_index;
  logic [WIDTH-1:0] stk_out;
  logic [1:0]       stk_error;
  logic [2:0]       stk_op;
  logic [IW-1:0]    stk_offset;
  logic [WIDTH-1:0] stk_data;
  logic [IW-1:0]    stk_underflow_limit;
  logic             done;
  logic [1:0]       err;
  logic [$clog2(FRAMES):0] depth;

  always #5 clk = ~clk;

  stack_frame_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES)) dut (
    .clk                 (clk),
    .reset               (reset),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_ret             (cmd_ret),
    .cmd_count           (cmd_count),
    .stk_index           (stk_index),
    .stk_out             (stk_out),
    .stk_error           (stk_error),
    .stk_op              (stk_op),
    .stk_offset          (stk_offset),
    .stk_data            (stk_data),
    .stk_underflow_limit (stk_underflow_limit),
    .done                (done),
    .err                 (err),
    .depth               (depth)
  );

  // stack stand-in: registered index/TOS/error, reacts to ops at the clock edge
  logic [WIDTH-1:0] m_mem [CAP];
  logic [IW-1:0]    m_idx = '0;
  logic [1:0]       m_err = '0;
  int               ops_seen = 0;
  logic             push_req = 1'b0;
  logic [WIDTH-1:0] push_val = '0;

  assign stk_index = m_idx;
  assign stk_out   = (m_idx == '0) ? '0 : m_mem[2'(m_idx - 3'd1)];
  assign stk_error = m_err;

  always @(posedge clk) begin
    m_err <= 2'd0;
    if (push_req) begin
      if (m_idx < IW'(CAP)) begin
        m_mem[m_idx[1:0]] <= push_val;
        m_idx <= m_idx + 3'd1;
      end else m_err <= 2'd2;
    end else if (stk_op == STK_INDEX_RESET) begin
      if (stk_offset <= m_idx) m_idx <= stk_offset;
      else m_err <= 2'd1;
    end else if (stk_op == STK_INDEX_RESET_AND_PUSH) begin
      if (stk_offset < IW'(CAP) && stk_offset <= m_idx) begin
        m_mem[stk_offset[1:0]] <= stk_data;
        m_idx <= stk_offset + 3'd1;
      end else m_err <= 2'd2;
    end
    if (stk_op != STK_NONE) ops_seen <= ops_seen + 1;
  end

  // reference model
  int lim;
  int frames[$];
  int exp_stk[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tb_push(input int v);
    @(negedge clk);
    push_req = 1'b1;
    push_val = v[WIDTH-1:0];
    @(negedge clk);
    push_req = 1'b0;
    exp_stk.push_back(v);
  endtask

  task automatic wait_ready(output bit ok);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    ok = cmd_ready;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
  endtask

  task automatic do_cmd(input bit ret, input int n);
    int idx, exp_err, exp_lat, exp_ops, ops0, lat, v;
    bit ok;
    idx = exp_stk.size();
    exp_ops = 0;
    exp_lat = 1;
    if (!ret) begin
      if (n > idx - lim) exp_err = 3;
      else if (frames.size() == FRAMES) exp_err = 1;
      else begin
        exp_err = 0;
        frames.push_back(lim);
        lim = idx - n;
      end
    end else begin
      if (frames.size() == 0) exp_err = 2;
      else if (n > 1 || (n == 1 && idx == lim)) exp_err = 3;
      else begin
        exp_err = 0;
        exp_lat = 3;
        exp_ops = 1;
        v = (n == 1) ? exp_stk[$] : 0;
        while (exp_stk.size() > lim) void'(exp_stk.pop_back());
        if (n == 1) exp_stk.push_back(v);
        lim = frames.pop_back();
      end
    end

    wait_ready(ok);
    if (!ok) return;
    ops0      = ops_seen;
    cmd_valid = 1'b1;
    cmd_ret   = ret;
    cmd_count = n[IW-1:0];
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got 0 expected 1");
      return;
    end
    check(ret ? "ret_latency" : "call_latency", lat, exp_lat);
    check(ret ? "ret_err" : "call_err", err, exp_err);
    check("depth", depth, frames.size());
    check("limit", stk_underflow_limit, lim);
    check("ops_issued", ops_seen - ops0, exp_ops);
    check("stk_index", stk_index, exp_stk.size());
    if (exp_stk.size() > 0) check("stk_tos", stk_out, exp_stk[$]);
  endtask

  initial begin
    bit ok;
    int saw_done, ops0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_ret   = 1'b0;
    cmd_count = '0;
    lim       = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_depth", depth, 0);
    check("rst_limit", stk_underflow_limit, 0);
    check("rst_op", stk_op, 0);
    check("rst_offset", stk_offset, 0);
    check("rst_data", stk_data, 0);
    reset = 1'b0;

    // return at depth 0
    do_cmd(1, 0);
    // call over two args, return one result
    tb_push(3); tb_push(4); tb_push(5);
    do_cmd(0, 2);
    tb_push(7);
    do_cmd(1, 1);
    // frame overflow, then unwind
    do_cmd(0, 0); do_cmd(0, 0); do_cmd(0, 0);
    do_cmd(1, 0); do_cmd(1, 0);
    // bad arity on call and on return from an empty frame
    do_cmd(0, 0);
    do_cmd(1, 1);
    tb_push(9);
    do_cmd(0, 3);
    do_cmd(1, 0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0 && exp_stk.size() < CAP) tb_push($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) do_cmd(1, $urandom_range(0, 2));
      else do_cmd(0, $urandom_range(0, 3));
    end

    // reset while a return is in its issue cycle
    if (frames.size() < FRAMES) do_cmd(0, 0);
    wait_ready(ok);
    if (ok) begin
      ops0      = ops_seen;
      cmd_valid = 1'b1;
      cmd_ret   = 1'b1;
      cmd_count = '0;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("midrst_op", stk_op, 0);
      check("midrst_limit", stk_underflow_limit, 0);
      check("midrst_depth", depth, 0);
      check("midrst_ready", cmd_ready, 1);
      check("midrst_done", done, 0);
      reset = 1'b0;
      frames.delete();
      lim = 0;
      saw_done = 0;
      repeat (6) begin
        @(negedge clk);
        if (done) saw_done++;
      end
      check("midrst_no_done", saw_done, 0);
      check("midrst_no_op", ops_seen - ops0, 0);
      do_cmd(1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
